pipe_decode_ctrl: RTL and testbench
===================================

Name: pipe_decode_ctrl

Overview:
- Registered, handshaked instruction-decode stage. Successor to the team's combinational field decoder.
- Sits between the instruction fetch buffer and the register-file/ALU stage.
- Decodes the fixed 32-bit format: bit31 type (0 R, 1 I), rs[30:25], rd[24:19], op[18:15], rt[14:9], imm[14:0].
- Adds parametrised immediate extension, load-use bubble insertion, a HALT state and a stall counter.

Parameters:
- DATA_W, 32, width of the extended immediate output; must be ≥ 15.
- SIGN_EXT, 1, 1 = sign-extend imm[14:0], 0 = zero-extend.
- CNT_W, 16, width of the saturating bubble counter.
- HALT_OP, 4'b1111, opcode that halts issue.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- inst  in  32  instruction word.
- out_valid  out  1  decode bundle valid.
- out_ready  in  1  downstream consumes the bundle.
- rs  out  6  source register 1.
- rt  out  6  source register 2; 0 for I-type.
- rd  out  6  destination register.
- alu_op  out  4  inst[18:15].
- imm  out  DATA_W  extended immediate; 0 for R-type.
- src_imm  out  1  inst[31].
- mem_to_reg  out  1  op == 4'b0100 (load).
- reg_we  out  1  0 for op 4'b0110 (store) and HALT_OP, else 1.
- mem_we  out  1  op == 4'b0110.
- halted  out  1  state == HALT.
- resume  in  1  single-cycle pulse that leaves HALT.
- bubble_cnt  out  CNT_W  number of load-use bubbles inserted.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid = 0; all bundle fields = 0; ld_pend = 0; ld_rd = 0; state = RUN; bubble_cnt = 0.
- Slot free: free = !out_valid | out_ready.
- Hazard: haz = ld_pend & ((inst rs == ld_rd) | (!inst[31] & inst rt == ld_rd)).
- in_ready = free & (state == RUN) & !haz. in_ready is combinational and depends on in_valid only through nothing: it is independent of in_valid.
- Accept (in_valid & in_ready): bundle registered next edge, out_valid = 1. Latency is one cycle from accept to out_valid.
- ld_pend: set to 1 with ld_rd = rd when the accepted instruction is a load. Cleared when a non-load is accepted or a bubble is inserted.
- Bubble insertion (in_valid & free & RUN & haz):
  - out_valid <= 0 and ld_pend <= 0.
  - bubble_cnt += 1, saturating at all-ones.
  - The instruction is held by fetch and accepted the following cycle. Exactly one bubble is inserted per load.
- Idle (free & !in_valid): out_valid <= 0. ld_pend is unchanged; a gap cycle does not clear the hazard.
- Backpressure (out_valid & !out_ready): bundle and out_valid hold stable; in_ready = 0.
- FSM: two states, RUN and HALT.
  - RUN -> HALT: on accept of op == HALT_OP. The HALT instruction is itself emitted with reg_we = 0 and mem_we = 0.
  - HALT -> RUN: on resume == 1. Acceptance resumes the next cycle.
  - resume while in RUN is ignored.
  - In HALT, in_ready = 0, but a pending output still drains normally.
- imm: if inst[31], imm = ext(inst[14:0]) per SIGN_EXT; otherwise imm = 0. Example: DATA_W = 32, SIGN_EXT = 1, imm field 0x4000 -> 0xFFFFC000.
- src_imm, mem_to_reg, reg_we, mem_we are pure functions of the accepted instruction, registered with the bundle.

Test Plan:
- Reset mid-stream: out_valid = 1, assert rst_n = 0 asynchronously -> out_valid = 0, bubble_cnt = 0 and halted = 0 immediately, without waiting for a clock edge.
- I-type decode: inst = 0x8000_4000 (src_imm = 1, imm field = 0x4000) -> one cycle later imm = 0xFFFF_C000 with SIGN_EXT = 1, and 0x0000_4000 with SIGN_EXT = 0.
- Load-use: load with rd = 5, then R-type with rs = 5, out_ready = 1:
  - -> out sequence is load, bubble (out_valid = 0), R-type; bubble_cnt = 1.
  - Same pair with rs = rt = 6 -> no bubble.
- Backpressure: out_ready = 0 for 3 cycles with out_valid = 1 -> bundle stable, in_ready = 0; the first cycle with out_ready = 1 accepts the next instruction.
- Store/halt: op 0110 -> reg_we = 0, mem_we = 1. Op 1111 -> reg_we = 0, mem_we = 0, halted = 1 next cycle, in_ready = 0 until a resume pulse, then accept resumes.
- Saturation: CNT_W = 2, force 5 load-use pairs -> bubble_cnt stops at 3.

Source files
------------

// File: rtl/pipe_decode_ctrl.sv
// Registered decode stage: one cycle from accept to out_valid, with one bubble inserted on a load-use hazard and a HALT state.
// Backpressure: the bundle holds while out_valid & !out_ready, and in_ready stays low until the slot frees.
module pipe_decode_ctrl #(
  parameter int         DATA_W   = 32,
  parameter bit         SIGN_EXT = 1'b1,
  parameter int         CNT_W    = 16,
  parameter logic [3:0] HALT_OP  = 4'b1111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        rs,
  output logic [5:0]        rt,
  output logic [5:0]        rd,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] imm,
  output logic              src_imm,
  output logic              mem_to_reg,
  output logic              reg_we,
  output logic              mem_we,
  output logic              halted,
  input  logic              resume,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [3:0] OP_LOAD  = 4'b0100;
  localparam logic [3:0] OP_STORE = 4'b0110;

  typedef enum logic {RUN, HALT} state_t;

  typedef struct packed {
    logic [5:0]        rs;
    logic [5:0]        rt;
    logic [5:0]        rd;
    logic [3:0]        op;
    logic [DATA_W-1:0] imm;
    logic              src_imm;
    logic              mem_to_reg;
    logic              reg_we;
    logic              mem_we;
  } bundle_t;

  state_t     state, state_d;
  bundle_t    dec, bundle_q;
  logic       ld_pend;
  logic [5:0] ld_rd;
  logic       free, haz, run, accept, bubble;

  always_comb begin
    dec            = '0;
    dec.rs         = inst[30:25];
    dec.rd         = inst[24:19];
    dec.op         = inst[18:15];
    dec.rt         = inst[31] ? 6'd0 : inst[14:9];
    dec.src_imm    = inst[31];
    dec.mem_to_reg = (inst[18:15] == OP_LOAD);
    dec.mem_we     = (inst[18:15] == OP_STORE);
    dec.reg_we     = !((inst[18:15] == OP_STORE) || (inst[18:15] == HALT_OP));
    if (inst[31]) begin
      dec.imm[14:0] = inst[14:0];
      for (int k = 15; k < DATA_W; k++) dec.imm[k] = SIGN_EXT & inst[14];
    end
  end

  // rt only participates in the hazard for R-type, where it is a real source
  assign haz    = ld_pend & ((inst[30:25] == ld_rd) | (!inst[31] & (inst[14:9] == ld_rd)));
  assign free   = !out_valid | out_ready;
  assign run    = (state == RUN);
  assign in_ready = free & run & !haz;
  assign accept = in_valid & in_ready;
  assign bubble = in_valid & free & run & haz;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      RUN:  if (accept && (inst[18:15] == HALT_OP)) state_d = HALT;
      HALT: if (resume) state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      bundle_q   <= '0;
      ld_pend    <= 1'b0;
      ld_rd      <= 6'd0;
      bubble_cnt <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      bundle_q  <= dec;
      ld_pend   <= dec.mem_to_reg;
      if (dec.mem_to_reg) ld_rd <= dec.rd;
    end else if (bubble) begin
      // the held instruction is accepted next cycle since ld_pend drops here
      out_valid <= 1'b0;
      ld_pend   <= 1'b0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end else if (free) begin
      out_valid <= 1'b0;
    end
  end

  assign rs         = bundle_q.rs;
  assign rt         = bundle_q.rt;
  assign rd         = bundle_q.rd;
  assign alu_op     = bundle_q.op;
  assign imm        = bundle_q.imm;
  assign src_imm    = bundle_q.src_imm;
  assign mem_to_reg = bundle_q.mem_to_reg;
  assign reg_we     = bundle_q.reg_we;
  assign mem_we     = bundle_q.mem_we;
  assign halted     = (state == HALT);

endmodule

// File: tb/tb_pipe_decode_ctrl.sv
// Bench for pipe_decode_ctrl: two instances (sign-extend/2-bit counter and zero-extend/16-bit counter) share one stimulus stream.
module tb_pipe_decode_ctrl;

  logic        clk, rst_n, in_valid, out_ready, resume;
  logic [31:0] inst;

  logic        in_ready, out_valid, src_imm, mem_to_reg, reg_we, mem_we, halted;
  logic [5:0]  rs, rt, rd;
  logic [3:0]  alu_op;
  logic [31:0] imm;
  logic [1:0]  bubble_cnt;

  logic        in_ready0, out_valid0, src_imm0, mem_to_reg0, reg_we0, mem_we0, halted0;
  logic [5:0]  rs0, rt0, rd0;
  logic [3:0]  alu_op0;
  logic [31:0] imm0;
  logic [15:0] bubble_cnt0;

  pipe_decode_ctrl #(.DATA_W(32), .SIGN_EXT(1'b1), .CNT_W(2), .HALT_OP(4'b1111)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .inst(inst),
    .out_valid(out_valid), .out_ready(out_ready), .rs(rs), .rt(rt), .rd(rd), .alu_op(alu_op),
    .imm(imm), .src_imm(src_imm), .mem_to_reg(mem_to_reg), .reg_we(reg_we), .mem_we(mem_we),
    .halted(halted), .resume(resume), .bubble_cnt(bubble_cnt));

  pipe_decode_ctrl #(.DATA_W(32), .SIGN_EXT(1'b0), .CNT_W(16), .HALT_OP(4'b1111)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0), .inst(inst),
    .out_valid(out_valid0), .out_ready(out_ready), .rs(rs0), .rt(rt0), .rd(rd0), .alu_op(alu_op0),
    .imm(imm0), .src_imm(src_imm0), .mem_to_reg(mem_to_reg0), .reg_we(reg_we0), .mem_we(mem_we0),
    .halted(halted0), .resume(resume), .bubble_cnt(bubble_cnt0));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [5:0]  rs, rt, rd;
    logic [3:0]  op;
    logic        src, m2r, rwe, mwe;
    logic [31:0] imm_s, imm_z;
  } exp_t;

  int   n_checks = 0;
  int   n_errs   = 0;
  exp_t m_b;
  logic m_vld, m_pend, m_halt, last_acc;
  logic [5:0] m_ld_rd;
  int   m_bub;

  localparam logic [31:0] LD  = 32'h002A_0000;  // load, rd=5
  localparam logic [31:0] R5  = 32'h0A00_0000;  // R-type, rs=5 rt=0
  localparam logic [31:0] R66 = 32'h0C00_0C00;  // R-type, rs=6 rt=6
  localparam logic [31:0] X   = 32'h1234_5678;  // R-type, rs=9 op=8
  localparam logic [31:0] ST  = 32'h0003_0000;  // store
  localparam logic [31:0] HT  = 32'h0007_8000;  // halt

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic exp_t dec(input logic [31:0] w);
    exp_t d;
    int   f;
    f       = int'(w[14:0]);
    d.rs    = w[30:25];
    d.rd    = w[24:19];
    d.op    = w[18:15];
    d.rt    = w[31] ? 6'd0 : w[14:9];
    d.src   = w[31];
    d.m2r   = (d.op == 4'd4);
    d.mwe   = (d.op == 4'd6);
    d.rwe   = !(d.op == 4'd6 || d.op == 4'd15);
    d.imm_z = w[31] ? 32'(f) : 32'd0;
    d.imm_s = !w[31] ? 32'd0 : (f >= 16384) ? 32'(f) + 32'hFFFF_8000 : 32'(f);
    return d;
  endfunction

  task automatic model_reset();
    m_vld = 0; m_pend = 0; m_halt = 0; m_ld_rd = 0; m_bub = 0; m_b = '0;
  endtask

  task automatic compare_outputs();
    logic [25:0] ectl;
    ectl = {m_b.rs, m_b.rt, m_b.rd, m_b.op, m_b.src, m_b.m2r, m_b.rwe, m_b.mwe};
    check("out_valid", out_valid, m_vld);
    check("out_valid0", out_valid0, m_vld);
    if (m_vld) begin
      check("ctl", {rs, rt, rd, alu_op, src_imm, mem_to_reg, reg_we, mem_we}, ectl);
      check("ctl0", {rs0, rt0, rd0, alu_op0, src_imm0, mem_to_reg0, reg_we0, mem_we0}, ectl);
      check("imm_sext", imm, m_b.imm_s);
      check("imm_zext", imm0, m_b.imm_z);
    end
    check("halted", halted, m_halt);
    check("halted0", halted0, m_halt);
    check("bubble_cnt_sat", bubble_cnt, (m_bub > 3) ? 3 : m_bub);
    check("bubble_cnt16", bubble_cnt0, m_bub % 65536);
  endtask

  // Called at a falling edge; drives one cycle of inputs, checks in_ready, advances the model and checks outputs.
  task automatic cyc(input logic v, input logic [31:0] w, input logic r, input logic res);
    exp_t d;
    logic free, haz, rdy, halt_old;
    in_valid = v; inst = w; out_ready = r; resume = res;
    #1;
    d        = dec(w);
    halt_old = m_halt;
    free     = !m_vld || r;
    haz      = m_pend && ((w[30:25] == m_ld_rd) || (!w[31] && (w[14:9] == m_ld_rd)));
    rdy      = free && !halt_old && !haz;
    check("in_ready", in_ready, rdy);
    check("in_ready0", in_ready0, rdy);
    last_acc = v && rdy;
    if (v && rdy) begin
      m_vld = 1; m_b = d; m_pend = d.m2r;
      if (d.m2r) m_ld_rd = d.rd;
      if (d.op == 4'd15) m_halt = 1;
    end else if (v && free && !halt_old && haz) begin
      m_vld = 0; m_pend = 0; m_bub++;
    end else if (free) begin
      m_vld = 0;
    end
    if (halt_old && res) m_halt = 0;
    @(negedge clk);
    compare_outputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       v;
    logic [31:0] w;
    rst_n = 0; in_valid = 0; inst = 0; out_ready = 0; resume = 0;
    model_reset();
    last_acc = 0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_fields", {rs, rt, rd, alu_op, src_imm, mem_to_reg, reg_we, mem_we, imm}, 0);
    check("rst_bubble_cnt", bubble_cnt0, 0);
    check("rst_halted", halted, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1;

    // I-type immediate extension
    cyc(1, 32'h8000_4000, 1, 0);
    check("itype_imm_sext", imm, 32'hFFFF_C000);
    check("itype_imm_zext", imm0, 32'h0000_4000);
    check("itype_src_imm", src_imm, 1);

    // load-use: load, bubble, R-type
    cyc(1, LD, 1, 0);
    check("lu_load_valid", {out_valid, mem_to_reg}, 2'b11);
    cyc(1, R5, 1, 0);
    check("lu_bubble_slot", out_valid, 0);
    check("lu_bubble_cnt", bubble_cnt, 1);
    cyc(1, R5, 1, 0);
    check("lu_rtype_after", {out_valid, rs}, {1'b1, 6'd5});

    // independent registers: no bubble
    cyc(1, LD, 1, 0);
    cyc(1, R66, 1, 0);
    check("nohaz_rtype", {out_valid, rs, rt}, {1'b1, 6'd6, 6'd6});
    check("nohaz_cnt", bubble_cnt0, 1);

    // backpressure for three cycles
    repeat (3) cyc(1, X, 0, 0);
    check("bp_stable", {out_valid, rs}, {1'b1, 6'd6});
    cyc(1, X, 1, 0);
    check("bp_release_accept", {out_valid, rs}, {1'b1, 6'd9});

    // store and halt
    cyc(1, ST, 1, 0);
    check("store_we", {reg_we, mem_we}, 2'b01);
    cyc(1, HT, 1, 0);
    check("halt_we", {reg_we, mem_we, halted}, 3'b001);
    repeat (2) cyc(1, X, 1, 0);
    check("halt_blocked", {out_valid, halted}, 2'b01);
    cyc(1, X, 1, 1);
    check("resume_leaves_halt", halted, 0);
    cyc(1, X, 1, 0);
    check("resume_accept", {out_valid, rs}, {1'b1, 6'd9});

    // saturation: five more load-use pairs
    for (int i = 0; i < 5; i++) begin
      cyc(1, LD, 1, 0);
      cyc(1, R5, 1, 0);
      cyc(1, R5, 1, 0);
    end
    check("sat_cnt2", bubble_cnt, 3);
    check("sat_cnt16", bubble_cnt0, 6);

    // asynchronous reset while a bundle is valid and the stage is halted
    cyc(1, HT, 1, 0);
    check("pre_rst_state", {out_valid, halted}, 2'b11);
    #2;
    rst_n = 0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_halted", halted, 0);
    check("arst_bubble_cnt", {bubble_cnt, bubble_cnt0}, 0);
    in_valid = 0; out_ready = 0; resume = 0;
    model_reset();
    last_acc = 0;
    @(negedge clk);
    rst_n = 1;

    // randomized traffic; fetch holds an instruction until it is taken
    v = 0; w = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!(v && !last_acc)) begin
        int r;
        logic [3:0] op;
        r  = $urandom_range(0, 99);
        op = (r < 30) ? 4'd4 : (r < 33) ? 4'd15 : 4'($urandom_range(0, 14));
        v  = ($urandom_range(0, 4) != 0);
        w  = {1'($urandom_range(0, 1)), 6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
              op, 6'($urandom_range(0, 3)), 9'($urandom)};
        if ($urandom_range(0, 3) == 0) w[14:0] = 15'($urandom);
      end
      cyc(v, w, ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
